// File: rtl/riscv_writeback.sv
// Writeback stage: arbitrates ALU results and extended load responses into one register-file write port.
// Optional RISCV_WB_SCOREBOARD_EN adds a per-register pending-write vector.
package riscv_wb_pkg;
    typedef enum logic {
        RF_DISABLE = 1'b0,
        RF_WRITE   = 1'b1
    } rf_wen_e;
endpackage

module riscv_writeback
    import riscv_wb_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   alu_valid,
    input  logic [ADDR_LENGTH-1:0] alu_rd,
    input  logic [WORD_LENGTH-1:0] alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_LENGTH-1:0] mem_rd,
    input  logic [WORD_LENGTH-1:0] mem_data,
    input  logic [2:0]             mem_funct3,
    input  logic [1:0]             mem_byte_off,
    output logic                   mem_ready,
    output rf_wen_e                write_en,
    output logic [ADDR_LENGTH-1:0] write_addr,
    output logic [WORD_LENGTH-1:0] data
`ifdef RISCV_WB_SCOREBOARD_EN
    ,
    output logic [2**ADDR_LENGTH-1:0] pending
`endif
);

    function automatic logic [WORD_LENGTH-1:0] load_extend(
        input logic [2:0]             f3,
        input logic [1:0]             off,
        input logic [WORD_LENGTH-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extend = {{(WORD_LENGTH-8){b[7]}}, b};
            3'b001:  load_extend = {{(WORD_LENGTH-16){h[15]}}, h};
            3'b100:  load_extend = {{(WORD_LENGTH-8){1'b0}}, b};
            3'b101:  load_extend = {{(WORD_LENGTH-16){1'b0}}, h};
            default: load_extend = w;
        endcase
    endfunction

    logic [ADDR_LENGTH-1:0] r_fifo_rd   [2];
    logic [WORD_LENGTH-1:0] r_fifo_data [2];
    logic                   r_wptr;
    logic                   r_rptr;
    logic [1:0]             r_count;
    logic [1:0]             r_starve_cnt;
    rf_wen_e                r_write_en;
    logic [ADDR_LENGTH-1:0] r_write_addr;
    logic [WORD_LENGTH-1:0] r_data;

    logic                   w_alu_ready;
    logic                   w_mem_ready;
    logic                   w_alu_acc;
    logic                   w_mem_acc;
    logic                   w_pop;
    logic [WORD_LENGTH-1:0] w_ext;

    // Ready generation; nothing is accepted while reset is asserted.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (reset_n) begin
            w_mem_ready = (r_count != 2'd2);
            w_alu_ready = (r_count == 2'd0) || (r_starve_cnt == 2'd3);
        end else begin
            w_mem_ready = 1'b0;
            w_alu_ready = 1'b0;
        end
    end

    assign w_alu_acc = alu_valid & w_alu_ready;
    assign w_mem_acc = mem_valid & w_mem_ready;
    assign w_pop     = (r_count != 2'd0) & ~w_alu_acc;
    assign w_ext     = load_extend(mem_funct3, mem_byte_off, mem_data);

    assign alu_ready  = w_alu_ready;
    assign mem_ready  = w_mem_ready;
    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign data       = r_data;

    // Two-entry load FIFO holding already-extended data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_rd[i]   <= {ADDR_LENGTH{1'b0}};
                r_fifo_data[i] <= {WORD_LENGTH{1'b0}};
            end
        end else begin
            if (w_mem_acc) begin
                r_fifo_rd[r_wptr]   <= mem_rd;
                r_fifo_data[r_wptr] <= w_ext;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_mem_acc, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Starvation counter: after three pops against a waiting ALU beat, the ALU gets the port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= 2'd0;
        end else if (w_alu_acc || !alu_valid) begin
            r_starve_cnt <= 2'd0;
        end else if (w_pop) begin
            r_starve_cnt <= r_starve_cnt + 2'd1;
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

    // Registered write port; address/data hold when no beat is selected.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_write_en   <= RF_DISABLE;
            r_write_addr <= {ADDR_LENGTH{1'b0}};
            r_data       <= {WORD_LENGTH{1'b0}};
        end else if (w_alu_acc) begin
            r_write_en   <= (alu_rd != {ADDR_LENGTH{1'b0}}) ? RF_WRITE : RF_DISABLE;
            r_write_addr <= alu_rd;
            r_data       <= alu_data;
        end else if (w_pop) begin
            r_write_en   <= (r_fifo_rd[r_rptr] != {ADDR_LENGTH{1'b0}}) ? RF_WRITE : RF_DISABLE;
            r_write_addr <= r_fifo_rd[r_rptr];
            r_data       <= r_fifo_data[r_rptr];
        end else begin
            r_write_en   <= RF_DISABLE;
            r_write_addr <= r_write_addr;
            r_data       <= r_data;
        end
    end

`ifdef RISCV_WB_SCOREBOARD_EN
    localparam int NREG = 2**ADDR_LENGTH;
    logic [NREG-1:0] w_one;
    logic [NREG-1:0] w_pend_head;
    logic [NREG-1:0] w_pend_tail;
    logic [NREG-1:0] w_pend_out;

    // x0 never counts as pending; the output register only counts when it is actually writing.
    assign w_one       = {{(NREG-1){1'b0}}, 1'b1};
    assign w_pend_head = ((r_count != 2'd0) && (r_fifo_rd[r_rptr] != {ADDR_LENGTH{1'b0}}))
                         ? (w_one << r_fifo_rd[r_rptr]) : {NREG{1'b0}};
    assign w_pend_tail = ((r_count == 2'd2) && (r_fifo_rd[~r_rptr] != {ADDR_LENGTH{1'b0}}))
                         ? (w_one << r_fifo_rd[~r_rptr]) : {NREG{1'b0}};
    assign w_pend_out  = (r_write_en == RF_WRITE) ? (w_one << r_write_addr) : {NREG{1'b0}};
    assign pending     = w_pend_head | w_pend_tail | w_pend_out;
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Randomized + directed bench for riscv_writeback against a queue-based reference model.
module tb_riscv_writeback;
    import riscv_wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_byte_off;
    logic        mem_ready;
    rf_wen_e     write_en;
    logic [4:0]  write_addr;
    logic [31:0] data;
`ifdef RISCV_WB_SCOREBOARD_EN
    logic [31:0] pending;
`endif

    always #5 clk = ~clk;

    riscv_writeback #(.WORD_LENGTH(32), .ADDR_LENGTH(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_funct3(mem_funct3), .mem_byte_off(mem_byte_off), .mem_ready(mem_ready),
        .write_en(write_en), .write_addr(write_addr), .data(data)
`ifdef RISCV_WB_SCOREBOARD_EN
        , .pending(pending)
`endif
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          starve;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_checks;
    int          n_errors;
    logic        s_alu_rdy;
    logic        s_mem_rdy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_extend(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] bv;
        logic [31:0] hv;
        bv = (w >> (8 * off)) & 32'hFF;
        hv = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (bv >= 32'd128) ? (bv | 32'hFFFFFF00) : bv;
            3'd1:    return (hv >= 32'd32768) ? (hv | 32'hFFFF0000) : hv;
            3'd4:    return bv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    task automatic step(input logic rn, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic [2:0] f3, input logic [1:0] off);
        logic ea, em, alu_acc, mem_acc, pop;
        ent_t e;
        logic [31:0] pend;
        @(negedge clk);
        reset_n = rn; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md; mem_funct3 = f3; mem_byte_off = off;
        #1;
        ea = rn && (q.size() == 0 || starve == 3);
        em = rn && (q.size() < 2);
        s_alu_rdy = alu_ready;
        s_mem_rdy = mem_ready;
        check_eq("alu_ready", alu_ready, ea);
        check_eq("mem_ready", mem_ready, em);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            starve = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        end else begin
            alu_acc = av && ea;
            mem_acc = mv && em;
            pop = (q.size() > 0) && !alu_acc;
            if (alu_acc) begin
                m_we = (ard != 5'd0); m_addr = ard; m_data = ad;
            end else if (pop) begin
                e = q.pop_front();
                m_we = (e.rd != 5'd0); m_addr = e.rd; m_data = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (mem_acc) begin
                e.rd = mrd; e.d = ref_extend(f3, off, md);
                q.push_back(e);
            end
            if (alu_acc || !av) starve = 0;
            else if (pop) starve = starve + 1;
        end
        #1;
        check_eq("write_en", write_en, m_we);
        check_eq("write_addr", write_addr, m_addr);
        check_eq("data", data, m_data);
`ifdef RISCV_WB_SCOREBOARD_EN
        pend = 32'd0;
        foreach (q[i]) if (q[i].rd != 5'd0) pend[q[i].rd] = 1'b1;
        if (m_we) pend[m_addr] = 1'b1;
        check_eq("pending", pending, pend);
`endif
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    endtask

    task automatic starve_run(input int last_k, input logic chk);
        for (int k = 0; k <= last_k; k++) begin
            step(1'b1, 1'b1, 5'd10, 32'hA000 + k, 1'b1, 5'd11, 32'h1000 + k, 3'd2, 2'd0);
            if (chk) begin
                check_eq("starve_alu_ready", s_alu_rdy, (k % 4) == 0);
                check_eq("full_mem_ready", s_mem_rdy, !((k % 4) == 1 && k > 1));
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        starve = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        reset_n = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'd0; mem_funct3 = 3'd0; mem_byte_off = 2'd0;

        // Beats offered during reset must be ignored.
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd9, 32'h2, 3'd2, 2'd0);
        step(1'b0, 1'b1, 5'd7, 32'h1, 1'b1, 5'd9, 32'h2, 3'd2, 2'd0);
        check_eq("rst_write_en", write_en, RF_DISABLE);
        check_eq("rst_data", data, 32'd0);

        step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        check_eq("alu_we", write_en, RF_WRITE);
        check_eq("alu_addr", write_addr, 5'd5);
        check_eq("alu_data", data, 32'h1234);

        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00800000, 3'b000, 2'd2);
        idle();
        check_eq("lb_data", data, 32'hFFFFFF80);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h00800000, 3'b100, 2'd2);
        idle();
        check_eq("lbu_data", data, 32'h00000080);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h80010000, 3'b001, 2'd2);
        idle();
        check_eq("lh_data", data, 32'hFFFF8001);
        check_eq("lh_addr", write_addr, 5'd4);
        idle();
        check_eq("hold_data", data, 32'hFFFF8001);

        starve_run(9, 1'b1);
        repeat (3) idle();

        step(1'b1, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        check_eq("x0_alu_ready", s_alu_rdy, 1'b1);
        check_eq("x0_write_en", write_en, RF_DISABLE);

        // Leave two entries in flight, then reset.
        starve_run(8, 1'b0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_eq("post_rst_we", write_en, RF_DISABLE);
        end

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), $urandom,
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
